sort_job_arbiter: RTL and testbench

//  Shares one fsm-style sort engine (start / data_in[N] -> done / data_sorted[N]) among R requesters.
//  - Round-robin selects a requester and snapshots its vector.
//  - Pulses the engine start, waits out its fixed latency, captures the result.
//  - Returns the result to the granted requester with a valid/ack handshake.
//  - A watchdog flags an engine that never completes.

---
 rtl/sort_job_arbiter.sv | 111 +++++++++++
 tb/tb_sort_job_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_arbiter.sv
// rtl/sort_job_arbiter.sv - round-robin front end sharing one fixed-latency sort engine among R requesters
module sort_job_arbiter #(
  parameter int R       = 4,
  parameter int N       = 6,
  parameter int WIDTH   = 8,
  parameter int ENG_LAT = 5,
  parameter int TIMEOUT = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [R-1:0]                     req,
  input  logic [R-1:0][N-1:0][WIDTH-1:0]   req_data,
  output logic [R-1:0]                     resp_valid,
  input  logic [R-1:0]                     resp_ack,
  output logic [N-1:0][WIDTH-1:0]          resp_data,
  output logic                             resp_err,
  output logic                             eng_start,
  output logic [N-1:0][WIDTH-1:0]          eng_data,
  input  logic                             eng_done,
  input  logic [N-1:0][WIDTH-1:0]          eng_sorted,
  output logic                             busy,
  output logic [15:0]                      job_cnt
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DONE_MIN = CW'(ENG_LAT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic [CW-1:0] wait_cnt;
  int            sum;

  // Scan from the highest offset down so the last hit is the one closest to rr_ptr.
  always_comb begin
    pick = rr_ptr;
    sum  = 0;
    for (int i = R - 1; i >= 0; i--) begin
      sum = int'(rr_ptr) + i;
      if (sum >= R) sum = sum - R;
      if (req[sum]) pick = IW'(sum);
    end
  end

  assign next_ptr  = (grant == IW'(R - 1)) ? '0 : grant + 1'b1;
  assign eng_start = (state == START);
  assign busy      = (state != IDLE);

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      wait_cnt  <= '0;
      eng_data  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      job_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= pick;
            eng_data <= req_data[pick];
            state    <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Early done is ignored: it may be left over from the previous job.
          if (wait_cnt >= DONE_MIN && eng_done) begin
            resp_data <= eng_sorted;
            resp_err  <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == TO_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (resp_ack[grant]) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
            if (!resp_err && job_cnt != 16'hFFFF) job_cnt <= job_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_job_arbiter.sv
// tb/tb_sort_job_arbiter.sv - self-checking bench for sort_job_arbiter with a behavioural sort engine
module tb_sort_job_arbiter;

  localparam int R       = 4;
  localparam int N       = 6;
  localparam int W       = 8;
  localparam int ENG_LAT = 5;
  localparam int TIMEOUT = 32;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {int r; vec_t data; vec_t exp;} vec_rec_t;
  typedef struct {int r; vec_t data; logic err;} sb_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [R-1:0]             req;
  logic [R-1:0][N-1:0][W-1:0] req_data;
  logic [R-1:0]             resp_valid;
  logic [R-1:0]             resp_ack;
  vec_t                     resp_data;
  logic                     resp_err;
  logic                     eng_start;
  vec_t                     eng_data;
  logic                     eng_done;
  vec_t                     eng_sorted;
  logic                     busy;
  logic [15:0]              job_cnt;

  int total = 0;
  int bad   = 0;
  int exp_jobs = 0;
  sb_t sb[$];
  vec_rec_t tbl[4];

  sort_job_arbiter #(.R(R), .N(N), .WIDTH(W), .ENG_LAT(ENG_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ack(resp_ack), .resp_data(resp_data),
    .resp_err(resp_err), .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_sorted(eng_sorted), .busy(busy), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t sort_vec(input vec_t v);
    vec_t s = v;
    logic [W-1:0] t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s;
  endfunction

  function automatic vec_t mk(input int a0, input int a1, input int a2,
                              input int a3, input int a4, input int a5);
    vec_t v;
    v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2);
    v[3] = W'(a3); v[4] = W'(a4); v[5] = W'(a5);
    return v;
  endfunction

  function automatic logic [R-1:0] one_hot(input int r);
    return R'(1) << r;
  endfunction

  // Engine: done rises ENG_LAT cycles after start; stale_mode keeps the old done/result visible.
  bit   stale_mode = 0;
  bit   dead_mode  = 0;
  int   lat        = 0;
  logic done_r     = 1'b0;
  vec_t pend       = '0;
  vec_t sorted_r   = '0;
  assign eng_done   = done_r;
  assign eng_sorted = sorted_r;

  always @(posedge clk) begin
    if (eng_start) begin
      lat  <= 1;
      pend <= sort_vec(eng_data);
      if (!stale_mode) done_r <= 1'b0;
    end else if (lat != 0 && lat < ENG_LAT) begin
      lat <= lat + 1;
      if (lat == ENG_LAT - 1 && !dead_mode) begin
        done_r   <= 1'b1;
        sorted_r <= pend;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic serve(input int exp_lat, input int hold, input logic [R-1:0] drop_mask);
    sb_t e;
    int  cnt  = 0;
    bit  seen = 0;
    while (cnt < 100 && !seen) begin
      @(negedge clk);
      cnt++;
      if (resp_valid != '0) seen = 1;
    end
    if (!seen) begin chk("resp_seen", 64'd0, 64'd1); return; end
    if (sb.size() == 0) begin chk("sb_empty", 64'd1, 64'd0); return; end
    e = sb.pop_front();
    chk("resp_valid", resp_valid, one_hot(e.r));
    if (exp_lat >= 0) chk("latency", cnt, exp_lat);
    chk("resp_data", resp_data, e.data);
    chk("resp_err", resp_err, e.err);
    for (int h = 0; h < hold; h++) begin
      resp_ack = one_hot((e.r + 1) % R);
      @(negedge clk);
      chk("hold_valid", resp_valid, one_hot(e.r));
      chk("hold_data", resp_data, e.data);
    end
    resp_ack = one_hot(e.r);
    req      = req & ~drop_mask;
    @(negedge clk);
    resp_ack = '0;
    if (!e.err) exp_jobs++;
    chk("valid_clr", resp_valid, 64'd0);
    chk("job_cnt", job_cnt, exp_jobs);
  endtask

  task automatic run_job(input int r, input vec_t data, input vec_t exp, input logic err,
                         input int exp_lat, input int hold);
    sb.push_back('{r: r, data: exp, err: err});
    req_data[r] = data;
    req[r]      = 1'b1;
    serve(exp_lat, hold, one_hot(r));
  endtask

  initial begin
    vec_t rrd[R];
    int   hits;

    tbl[0] = '{r: 2, data: mk(5, 3, 9, 1, 7, 2),         exp: mk(1, 2, 3, 5, 7, 9)};
    tbl[1] = '{r: 0, data: mk(0, 255, 128, 1, 1, 0),     exp: mk(0, 0, 1, 1, 128, 255)};
    tbl[2] = '{r: 1, data: mk(9, 8, 7, 6, 5, 4),         exp: mk(4, 5, 6, 7, 8, 9)};
    tbl[3] = '{r: 3, data: mk(10, 20, 30, 40, 50, 60),   exp: mk(10, 20, 30, 40, 50, 60)};

    rst_n = 1'b0; req = '0; req_data = '0; resp_ack = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", resp_valid, 64'd0);
    chk("rst_busy", busy, 64'd0);
    chk("rst_start", eng_start, 64'd0);
    chk("rst_job_cnt", job_cnt, 64'd0);
    chk("rst_err", resp_err, 64'd0);
    chk("rst_eng_data", eng_data, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    rst_n = 1'b1;

    // Single jobs; eng_start must follow the grant by one cycle.
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{r: tbl[i].r, data: tbl[i].exp, err: 1'b0});
      req_data[tbl[i].r] = tbl[i].data;
      req[tbl[i].r]      = 1'b1;
      @(negedge clk);
      chk("eng_start", eng_start, 64'd1);
      chk("eng_data", eng_data, tbl[i].data);
      serve(6, 0, one_hot(tbl[i].r));
    end

    // Round robin with every requester held high: 0,1,2,3 then wrap to 0.
    for (int r = 0; r < R; r++) begin
      rrd[r] = mk(40 - r, 3, 17 * r, 200, r, 99);
      req_data[r] = rrd[r];
    end
    for (int k = 0; k < 5; k++) sb.push_back('{r: k % R, data: sort_vec(rrd[k % R]), err: 1'b0});
    req = '1;
    serve(7, 0, '0);
    for (int k = 1; k < 4; k++) serve(-1, 0, '0);
    serve(-1, 0, '1);

    // Stale done held high from the previous job must not be captured early.
    stale_mode = 1;
    run_job(1, mk(3, 1, 2, 6, 5, 4), mk(1, 2, 3, 4, 5, 6), 1'b0, 7, 0);
    run_job(1, mk(90, 80, 70, 60, 50, 45), mk(45, 50, 60, 70, 80, 90), 1'b0, 7, 0);
    stale_mode = 0;

    // Engine never completes: error response after TIMEOUT WAIT cycles.
    dead_mode = 1;
    run_job(0, mk(1, 2, 3, 4, 5, 6), '0, 1'b1, TIMEOUT + 2, 0);
    dead_mode = 0;

    // Backpressure with wrong-index acks during the hold.
    run_job(2, mk(7, 7, 1, 0, 200, 3), mk(0, 1, 3, 7, 7, 200), 1'b0, 7, 10);

    // Reset in WAIT drops the job.
    req_data[1] = mk(1, 1, 1, 1, 1, 1);
    req[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 64'd1);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 64'd0);
    chk("rst_mid_valid", resp_valid, 64'd0);
    rst_n = 1'b1;
    hits  = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid != '0) hits++;
    end
    chk("dropped_job", hits, 64'd0);
    chk("rst_mid_job_cnt", job_cnt, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
